// File: rtl/cmac_seq.sv
// Initiator-side sequencer for a packed 8-bit complex multiplier.
// Streams N_TERMS operand pairs through one multiplier using its start/done handshake.
// Accumulates the complex products into a dot product and pulses done when the sum is ready.
module cmac_seq #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             in_ready,
  output logic             mult_start,
  output logic [7:0]       mult_a,
  output logic [7:0]       mult_b,
  input  logic             mult_done,
  input  logic [7:0]       mult_real,
  input  logic [7:0]       mult_imag,
  output logic [ACC_W-1:0] acc_real,
  output logic [ACC_W-1:0] acc_imag,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(N_TERMS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWaitLo,
    StWaitHi,
    StAccum,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_re_q, acc_re_d;
  logic [ACC_W-1:0]  acc_im_q, acc_im_d;
  logic [7:0]        op_a_q, op_a_d;
  logic [7:0]        op_b_q, op_b_d;
  logic              mult_start_q, mult_start_d;

  // Next-state, operand capture and accumulation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_re_d     = acc_re_q;
    acc_im_d     = acc_im_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    mult_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d    = '0;
          acc_re_d = '0;
          acc_im_d = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Start is registered on ISSUE exit so no input reaches an output combinationally;
        // the multiplier sees it during the first WAIT_LO cycle and drops done after that.
        if (mult_done) begin
          mult_start_d = 1'b1;
          state_d      = StWaitLo;
        end
      end
      StWaitLo: begin
        if (!mult_done) state_d = StWaitHi;
      end
      StWaitHi: begin
        if (mult_done) state_d = StAccum;
      end
      StAccum: begin
        // Products are signed; sign-extend and let the sum wrap modulo 2^ACC_W.
        acc_re_d = acc_re_q + ACC_W'($signed(mult_real));
        acc_im_d = acc_im_q + ACC_W'($signed(mult_imag));
        cnt_d    = cnt_q + CntW'(1);
        state_d  = (cnt_d == CntW'(N_TERMS)) ? StFinish : StFetch;
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counter, accumulators and operand registers; reset aborts any run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      mult_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_re_q     <= acc_re_d;
      acc_im_q     <= acc_im_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      mult_start_q <= mult_start_d;
    end
  end

  // Outputs are either registers or decodes of the state register.
  always_comb begin
    in_ready   = (state_q == StFetch);
    busy       = (state_q != StIdle);
    done       = (state_q == StFinish);
    mult_start = mult_start_q;
    mult_a     = op_a_q;
    mult_b     = op_b_q;
    acc_real   = acc_re_q;
    acc_imag   = acc_im_q;
  end

endmodule

// File: tb/tb_cmac_seq.sv
// Self-checking bench for cmac_seq: three instances (N=1, N=3, N=3 with 8-bit accumulators),
// each driving a behavioural complex multiplier with a fixed busy time and a hold-off control.
module tb_cmac_seq;

  localparam int NI  = 3;
  localparam int Lat = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NI-1:0]        start, in_valid, in_ready, m_start, m_done, busy, done, hold, pend;
  logic [NI-1:0][7:0]   in_a, in_b, m_a, m_b, m_re, m_im;
  logic [NI-1:0][3:0]   m_cnt;
  logic [11:0]          acc_re1, acc_im1, acc_re3, acc_im3;
  logic [7:0]           acc_re8, acc_im8;
  int                   n_start [NI];
  int                   n_done  [NI];
  int                   tests, fails;

  cmac_seq #(.N_TERMS(1), .ACC_W(12)) u_n1 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_a(in_a[0]),
    .in_b(in_b[0]), .in_ready(in_ready[0]), .mult_start(m_start[0]), .mult_a(m_a[0]),
    .mult_b(m_b[0]), .mult_done(m_done[0]), .mult_real(m_re[0]), .mult_imag(m_im[0]),
    .acc_real(acc_re1), .acc_imag(acc_im1), .busy(busy[0]), .done(done[0])
  );

  cmac_seq #(.N_TERMS(3), .ACC_W(12)) u_n3 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_a(in_a[1]),
    .in_b(in_b[1]), .in_ready(in_ready[1]), .mult_start(m_start[1]), .mult_a(m_a[1]),
    .mult_b(m_b[1]), .mult_done(m_done[1]), .mult_real(m_re[1]), .mult_imag(m_im[1]),
    .acc_real(acc_re3), .acc_imag(acc_im3), .busy(busy[1]), .done(done[1])
  );

  cmac_seq #(.N_TERMS(3), .ACC_W(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid[2]), .in_a(in_a[2]),
    .in_b(in_b[2]), .in_ready(in_ready[2]), .mult_start(m_start[2]), .mult_a(m_a[2]),
    .mult_b(m_b[2]), .mult_done(m_done[2]), .mult_real(m_re[2]), .mult_imag(m_im[2]),
    .acc_real(acc_re8), .acc_imag(acc_im8), .busy(busy[2]), .done(done[2])
  );

  // (ar + j*ai)(br + j*bi) with unsigned nibble components, truncated to 8 bits.
  function automatic logic [7:0] cre(logic [7:0] a, logic [7:0] b);
    int v;
    v = int'(a[7:4]) * int'(b[7:4]) - int'(a[3:0]) * int'(b[3:0]);
    return v[7:0];
  endfunction

  function automatic logic [7:0] cim(logic [7:0] a, logic [7:0] b);
    int v;
    v = int'(a[7:4]) * int'(b[3:0]) + int'(a[3:0]) * int'(b[7:4]);
    return v[7:0];
  endfunction

  // Multiplier models: load operands the cycle after start, then stay busy for Lat cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        pend[k]  <= 1'b0;
        m_cnt[k] <= '0;
        m_re[k]  <= '0;
        m_im[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        pend[k] <= m_start[k];
        if (pend[k]) begin
          m_re[k]  <= cre(m_a[k], m_b[k]);
          m_im[k]  <= cim(m_a[k], m_b[k]);
          m_cnt[k] <= 4'(Lat);
        end else if (m_cnt[k] != 0) begin
          m_cnt[k] <= m_cnt[k] - 4'd1;
        end
      end
    end
  end

  // Done is high while idle; hold forces it low to mimic another user of the multiplier.
  always_comb begin
    m_done = '0;
    for (int k = 0; k < NI; k++) m_done[k] = !pend[k] && (m_cnt[k] == 0) && !hold[k];
  end

  // Pulse counters for start and done.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (m_start[k]) n_start[k] <= n_start[k] + 1;
      if (done[k])    n_done[k]  <= n_done[k] + 1;
    end
  end

  task automatic pulse_start(input int k);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Present one pair and hold it until accepted (bounded).
  task automatic feed(input int k, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_a[k]     = a;
    in_b[k]     = b;
    while (!in_ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL feed_timeout[%0d]: in_ready stayed 0, required 1", k);
    end
  endtask

  // Return at the negedge where done is high (bounded).
  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!done[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL done_timeout[%0d]: done stayed 0, required 1", k);
    end
  endtask

  task automatic test_reset_por();
    #1;
    tests++;
    if ({busy, in_ready, m_start, done} !== '0) begin
      fails++;
      $display("FAIL por_ctrl: got %h required 0", {busy, in_ready, m_start, done});
    end
    tests++;
    if ({acc_re1, acc_im1, acc_re3, acc_im3, acc_re8, acc_im8, m_a, m_b} !== '0) begin
      fails++;
      $display("FAIL por_data: got %h required 0",
               {acc_re1, acc_im1, acc_re3, acc_im3, acc_re8, acc_im8, m_a, m_b});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if (busy !== '0) begin
        fails++;
        $display("FAIL por_idle_busy: got %b required 000", busy);
      end
    end
  endtask

  task automatic test_single();
    int s0;
    s0 = n_start[0];
    pulse_start(0);
    feed(0, 8'h23, 8'h21);
    wait_done(0);
    tests++;
    if (acc_re1 !== 12'd1) begin
      fails++;
      $display("FAIL single_real: got %0h required 1", acc_re1);
    end
    tests++;
    if (acc_im1 !== 12'd8) begin
      fails++;
      $display("FAIL single_imag: got %0h required 8", acc_im1);
    end
    @(negedge clk);
    tests++;
    if (n_start[0] - s0 !== 1) begin
      fails++;
      $display("FAIL single_start_pulses: got %0d required 1", n_start[0] - s0);
    end
    tests++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL single_done_width: done=%b busy=%b required 0 0", done[0], busy[0]);
    end
  endtask

  task automatic test_dot();
    int s0;
    int n;
    s0 = n_start[1];
    pulse_start(1);
    feed(1, 8'h23, 8'h21);
    feed(1, 8'h22, 8'h12);
    n = 0;
    while (!in_ready[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (acc_re3 !== 12'hFFF || acc_im3 !== 12'd14) begin
      fails++;
      $display("FAIL dot_mid: got %h/%h required fff/00e", acc_re3, acc_im3);
    end
    feed(1, 8'h10, 8'h13);
    wait_done(1);
    tests++;
    if (acc_re3 !== 12'd0 || acc_im3 !== 12'd17) begin
      fails++;
      $display("FAIL dot_final: got %h/%h required 000/011", acc_re3, acc_im3);
    end
    @(negedge clk);
    tests++;
    if (n_start[1] - s0 !== 3) begin
      fails++;
      $display("FAIL dot_start_pulses: got %0d required 3", n_start[1] - s0);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    pulse_start(1);
    feed(1, 8'h23, 8'h21);
    n = 0;
    while (!m_start[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    tests++;
    if (busy[1] !== 1'b1 || m_done[1] !== 1'b0) begin
      fails++;
      $display("FAIL midrun_setup: busy=%b mult_done=%b required 1 0", busy[1], m_done[1]);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, in_ready, m_start, done} !== '0) begin
      fails++;
      $display("FAIL midrun_ctrl: got %h required 0", {busy, in_ready, m_start, done});
    end
    tests++;
    if ({m_a[1], m_b[1]} !== 16'h0) begin
      fails++;
      $display("FAIL midrun_operands: got %h required 0000", {m_a[1], m_b[1]});
    end
    tests++;
    if ({acc_re1, acc_im1} !== 24'h0) begin
      fails++;
      $display("FAIL midrun_acc: got %h required 000000", {acc_re1, acc_im1});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (busy !== '0 || m_start !== '0) begin
      fails++;
      $display("FAIL midrun_no_resume: busy=%b mult_start=%b required 000 000", busy, m_start);
    end
  endtask

  task automatic test_stalls();
    int s0;
    int n;
    logic bad;
    pulse_start(1);
    s0 = n_start[1];
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready[1] !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad || n_start[1] != s0) begin
      fails++;
      $display("FAIL stall_fetch: ready_drop=%b starts=%0d required 0 0", bad, n_start[1] - s0);
    end
    hold[1] = 1'b1;
    feed(1, 8'h23, 8'h21);
    // Foreign pair and start while busy must both be ignored.
    in_valid[1] = 1'b1;
    in_a[1]     = 8'hFF;
    in_b[1]     = 8'hEE;
    start[1]    = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_start[1] !== 1'b0 || m_a[1] !== 8'h23 || m_b[1] !== 8'h21) bad = 1'b1;
    end
    tests++;
    if (bad || n_start[1] != s0) begin
      fails++;
      $display("FAIL stall_issue: glitch=%b starts=%0d required 0 0", bad, n_start[1] - s0);
    end
    in_valid[1] = 1'b0;
    start[1]    = 1'b0;
    hold[1]     = 1'b0;
    n = 0;
    bad = 1'b0;
    @(negedge clk);
    while (!in_ready[1] && n < 100) begin
      if (m_a[1] !== 8'h23 || m_b[1] !== 8'h21) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL stall_operands: got %h/%h required 23/21", m_a[1], m_b[1]);
    end
    tests++;
    if (n_start[1] - s0 !== 1) begin
      fails++;
      $display("FAIL stall_start_pulses: got %0d required 1", n_start[1] - s0);
    end
    feed(1, 8'h22, 8'h12);
    feed(1, 8'h10, 8'h13);
    wait_done(1);
    tests++;
    if (acc_re3 !== 12'd0 || acc_im3 !== 12'd17) begin
      fails++;
      $display("FAIL stall_final: got %h/%h required 000/011", acc_re3, acc_im3);
    end
  endtask

  task automatic test_wrap();
    pulse_start(2);
    repeat (3) feed(2, 8'hD1, 8'hA3);
    wait_done(2);
    tests++;
    if (acc_re8 !== 8'h7D) begin
      fails++;
      $display("FAIL wrap_real: got %h required 7d", acc_re8);
    end
    tests++;
    if (acc_im8 !== 8'h93) begin
      fails++;
      $display("FAIL wrap_imag: got %h required 93", acc_im8);
    end
  endtask

  task automatic test_restart();
    int d0;
    @(negedge clk);
    d0 = n_done[1];
    start[1] = 1'b1;
    feed(1, 8'h23, 8'h21);
    feed(1, 8'h22, 8'h12);
    feed(1, 8'h10, 8'h13);
    wait_done(1);
    tests++;
    if (acc_re3 !== 12'd0 || acc_im3 !== 12'd17) begin
      fails++;
      $display("FAIL restart_run1: got %h/%h required 000/011", acc_re3, acc_im3);
    end
    @(negedge clk);
    tests++;
    if (done[1] !== 1'b0 || busy[1] !== 1'b0) begin
      fails++;
      $display("FAIL restart_idle: done=%b busy=%b required 0 0", done[1], busy[1]);
    end
    @(negedge clk);
    tests++;
    if (busy[1] !== 1'b1 || in_ready[1] !== 1'b1 || acc_re3 !== 12'd0 || acc_im3 !== 12'd0) begin
      fails++;
      $display("FAIL restart_clear: busy=%b ready=%b acc=%h/%h required 1 1 000/000",
               busy[1], in_ready[1], acc_re3, acc_im3);
    end
    start[1] = 1'b0;
    feed(1, 8'h23, 8'h21);
    feed(1, 8'h22, 8'h12);
    feed(1, 8'h10, 8'h13);
    wait_done(1);
    tests++;
    if (acc_re3 !== 12'd0 || acc_im3 !== 12'd17) begin
      fails++;
      $display("FAIL restart_run2: got %h/%h required 000/011", acc_re3, acc_im3);
    end
    @(negedge clk);
    tests++;
    if (n_done[1] - d0 !== 2 || busy[1] !== 1'b0) begin
      fails++;
      $display("FAIL restart_done_pulses: got %0d busy=%b required 2 0", n_done[1] - d0, busy[1]);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    start    = '0;
    in_valid = '0;
    hold     = '0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(negedge clk);
    test_reset_por();
    test_single();
    test_dot();
    test_reset_midrun();
    test_stalls();
    test_wrap();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
